// File: rtl/hb_period_meter.sv
// Heartbeat period meter: times the interval between hb_in pulses, averages a window of
// 2^AVG_LOG2 intervals, hands the QF average period to the reciprocal unit and publishes
// the resulting rate with a one-cycle valid strobe.
module hb_period_meter #(
  parameter int unsigned W        = 32,
  parameter int unsigned F        = 16,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         hb_in,
  output logic         recip_start,
  output logic [W-1:0] recip_x,
  input  logic         recip_done,
  input  logic [W-1:0] recip_inv,
  input  logic         recip_invalid,
  output logic [W-1:0] rate_out,
  output logic         rate_valid,
  output logic         rate_err,
  output logic         busy,
  output logic         overrun
);

  // Counter width chosen so its all-ones value is the largest positive integer period in QF.
  localparam int unsigned CW = W - 1 - F;
  localparam int unsigned SW = W + AVG_LOG2;
  localparam int unsigned NW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0] PMAX  = {CW{1'b1}};
  localparam logic [NW-1:0] NLAST = NW'((1 << AVG_LOG2) - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [CW-1:0] cnt_q;
  logic          armed_q;
  logic [SW-1:0] sum_q;
  logic [NW-1:0] nsmp_q;
  logic          wsat_q;
  logic          win_done_q;
  logic [W-1:0]  win_x_q;
  logic          win_sat_q;

  logic [1:0]    state_q;
  logic [W-1:0]  recip_x_q;
  logic          err_sat_q;
  logic [W-1:0]  inv_q;
  logic          invalid_q;
  logic          drop_q;
  logic [W-1:0]  rate_out_q;
  logic          rate_valid_q;
  logic          rate_err_q;
  logic          overrun_q;

  logic          sample_take;
  logic          sample_sat;
  logic          win_last;
  logic [SW-1:0] sum_nxt;
  logic [SW-1:0] avg;
  logic [W-1:0]  win_x_nxt;

  // Sample and window arithmetic; the average never exceeds PMAX so the shift cannot overflow.
  always_comb begin
    sample_take = enable & hb_in & armed_q;
    sample_sat  = (cnt_q == PMAX);
    win_last    = (nsmp_q == NLAST);
    sum_nxt     = sum_q + SW'(cnt_q);
    avg         = sum_nxt >> AVG_LOG2;
    win_x_nxt   = W'(avg << F);
  end

  // Period counter and arming: the first pulse after enable only arms the meter.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else if (hb_in) begin
      cnt_q   <= CW'(1);
      armed_q <= 1'b1;
    end else if (cnt_q != PMAX) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Window accumulator; win_done_q pulses for one cycle after the window's last sample.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      sum_q      <= '0;
      nsmp_q     <= '0;
      wsat_q     <= 1'b0;
      win_done_q <= 1'b0;
      win_x_q    <= '0;
      win_sat_q  <= 1'b0;
    end else begin
      win_done_q <= 1'b0;
      if (sample_take) begin
        if (win_last) begin
          win_done_q <= 1'b1;
          win_x_q    <= win_x_nxt;
          win_sat_q  <= wsat_q | sample_sat;
          sum_q      <= '0;
          nsmp_q     <= '0;
          wsat_q     <= 1'b0;
        end else begin
          sum_q  <= sum_nxt;
          nsmp_q <= nsmp_q + NW'(1);
          wsat_q <= wsat_q | sample_sat;
        end
      end
    end
  end

  // Reciprocal handshake sequencer and published outputs. An in-flight request always
  // completes; if enable dropped meanwhile its result is discarded via drop_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      recip_x_q    <= '0;
      err_sat_q    <= 1'b0;
      inv_q        <= '0;
      invalid_q    <= 1'b0;
      drop_q       <= 1'b0;
      rate_out_q   <= '0;
      rate_valid_q <= 1'b0;
      rate_err_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rate_valid_q <= 1'b0;
      if (!enable) begin
        overrun_q <= 1'b0;
      end else if (win_done_q && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (win_done_q && enable) begin
            recip_x_q <= win_x_q;
            err_sat_q <= win_sat_q;
            drop_q    <= 1'b0;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          if (!enable) drop_q <= 1'b1;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (!enable) drop_q <= 1'b1;
          if (recip_done) begin
            inv_q     <= recip_inv;
            invalid_q <= recip_invalid;
            state_q   <= S_OUT;
          end
        end
        S_OUT: begin
          if (!drop_q) begin
            rate_out_q   <= inv_q;
            rate_err_q   <= invalid_q | err_sat_q;
            rate_valid_q <= 1'b1;
          end
          drop_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Output mapping.
  always_comb begin
    recip_start = (state_q == S_REQ);
    recip_x     = recip_x_q;
    rate_out    = rate_out_q;
    rate_valid  = rate_valid_q;
    rate_err    = rate_err_q;
    busy        = (state_q != S_IDLE);
    overrun     = overrun_q;
  end

endmodule

// File: tb/tb_hb_period_meter.sv
// Self-checking bench for hb_period_meter: behavioural reciprocal responders plus
// scoreboard queues for the requested period (at recip_start) and the published rate.
module tb_hb_period_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en1, hb1, en0, hb0;
  logic start1, start0;
  logic [31:0] x1, x0;
  logic done1 = 1'b0, done0 = 1'b0;
  logic [31:0] inv1 = '0, inv0 = '0;
  logic invd1 = 1'b0, invd0 = 1'b0;
  logic [31:0] rate1, rate0;
  logic rv1, rv0, re1, re0, busy1, busy0, ovr1, ovr0;

  // Default configuration (window of 4 intervals).
  hb_period_meter #(.W(32), .F(16), .AVG_LOG2(2)) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .hb_in(hb1),
    .recip_start(start1), .recip_x(x1), .recip_done(done1), .recip_inv(inv1),
    .recip_invalid(invd1), .rate_out(rate1), .rate_valid(rv1), .rate_err(re1),
    .busy(busy1), .overrun(ovr1)
  );

  // Single-interval windows.
  hb_period_meter #(.W(32), .F(16), .AVG_LOG2(0)) dut0 (
    .clk(clk), .rst(rst), .enable(en0), .hb_in(hb0),
    .recip_start(start0), .recip_x(x0), .recip_done(done0), .recip_inv(inv0),
    .recip_invalid(invd0), .rate_out(rate0), .rate_valid(rv0), .rate_err(re0),
    .busy(busy0), .overrun(ovr0)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int last_hb = 0;

  typedef struct {
    logic [31:0] rate;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        rq1[$], rq0[$];
  logic [31:0] xq1[$], xq0[$];
  exp_t        e1, e0;
  logic [31:0] ex1, ex0;
  logic [31:0] rx1, rx0;
  int          rc1 = 0, rc0 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred with nothing expected", name);
  endtask

  function automatic logic [31:0] recip(input logic [31:0] x);
    if ($signed(x) <= 0) return '1;
    return 32'((64'd1 << 32) / {32'd0, x});
  endfunction

  // Reciprocal responders: sample x at start, answer 9 cycles later, done for one cycle.
  always @(negedge clk) begin
    done1 = 1'b0;
    if (rc1 > 0) begin
      rc1--;
      if (rc1 == 0) begin
        done1 = 1'b1;
        inv1  = recip(rx1);
        invd1 = ($signed(rx1) <= 0);
      end
    end
    if (start1) begin
      if (xq1.size() == 0) fail("start1_unexpected");
      else begin
        ex1 = xq1.pop_front();
        chk("recip_x1", x1, ex1);
      end
      rx1 = x1;
      rc1 = 9;
    end
  end

  always @(negedge clk) begin
    done0 = 1'b0;
    if (rc0 > 0) begin
      rc0--;
      if (rc0 == 0) begin
        done0 = 1'b1;
        inv0  = recip(rx0);
        invd0 = ($signed(rx0) <= 0);
      end
    end
    if (start0) begin
      if (xq0.size() == 0) fail("start0_unexpected");
      else begin
        ex0 = xq0.pop_front();
        chk("recip_x0", x0, ex0);
      end
      rx0 = x0;
      rc0 = 9;
    end
  end

  // Rate monitors.
  always @(negedge clk) begin
    if (rv1) begin
      if (rq1.size() == 0) fail("rate_valid1_unexpected");
      else begin
        e1 = rq1.pop_front();
        chk("rate_out1", rate1, e1.rate);
        chk("rate_err1", {31'd0, re1}, {31'd0, e1.err});
        chk("latency1", cyc, e1.cyc);
      end
    end
    if (rv0) begin
      if (rq0.size() == 0) fail("rate_valid0_unexpected");
      else begin
        e0 = rq0.pop_front();
        chk("rate_out0", rate0, e0.rate);
        chk("rate_err0", {31'd0, re0}, {31'd0, e0.err});
        chk("latency0", cyc, e0.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse heartbeat `gap` cycles after the previous pulse.
  task automatic pulse(input int gap, input bit sel);
    repeat (gap - 1) tick();
    if (sel) hb1 = 1'b1;
    else hb0 = 1'b1;
    last_hb = cyc;
    tick();
    hb1 = 1'b0;
    hb0 = 1'b0;
  endtask

  task automatic push1(input logic [31:0] x, input logic [31:0] rate, input logic err);
    exp_t e;
    xq1.push_back(x);
    e.rate = rate;
    e.err  = err;
    e.cyc  = last_hb + 13;
    rq1.push_back(e);
  endtask

  task automatic settle();
    int n;
    repeat (3) tick();
    n = 0;
    while ((busy1 || busy0) && n < 60) begin
      tick();
      n++;
    end
    chk("settle_idle", {30'd0, busy1, busy0}, 32'd0);
    repeat (2) tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rate_out"}, rate1, 32'd0);
    chk({tag, "_recip_x"}, x1, 32'd0);
    chk({tag, "_rate_valid"}, {31'd0, rv1}, 32'd0);
    chk({tag, "_rate_err"}, {31'd0, re1}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy1}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, ovr1}, 32'd0);
    chk({tag, "_recip_start"}, {31'd0, start1}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    exp_t e;
    rst = 1'b1; en1 = 1'b0; hb1 = 1'b0; en0 = 1'b0; hb0 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk_reset("reset");

    // Steady 4-cycle heartbeat: average 4 -> x = 4<<16, rate = 2^32/2^18.
    en1 = 1'b1;
    repeat (5) pulse(4, 1'b1);
    push1(32'd262144, 32'd16384, 1'b0);
    settle();
    chk("hold_recip_x", x1, 32'd262144);

    // Intervals 3,5,4,6: sum 18, truncated average 4.
    en1 = 1'b0; tick(); en1 = 1'b1;
    pulse(2, 1'b1);
    pulse(3, 1'b1); pulse(5, 1'b1); pulse(4, 1'b1); pulse(6, 1'b1);
    push1(32'd262144, 32'd16384, 1'b0);
    settle();

    // Saturated interval: (4+4+4+32767)>>2 = 8194, x = 8194<<16, rate 7, error flagged.
    en1 = 1'b0; tick(); en1 = 1'b1;
    pulse(2, 1'b1);
    repeat (3) pulse(4, 1'b1);
    pulse(33000, 1'b1);
    push1(32'd537001984, 32'd7, 1'b1);
    settle();
    chk("no_overrun_sat", {31'd0, ovr1}, 32'd0);

    // Overrun then enable drop during S_WAIT: request completes, result discarded.
    en1 = 1'b0; tick(); en1 = 1'b1;
    pulse(2, 1'b1);
    repeat (4) pulse(2, 1'b1);
    xq1.push_back(32'd131072);
    repeat (4) pulse(2, 1'b1);
    n = 0;
    while (!ovr1 && n < 10) begin
      tick();
      n++;
    end
    chk("overrun_set", {31'd0, ovr1}, 32'd1);
    en1 = 1'b0;
    tick();
    chk("overrun_cleared", {31'd0, ovr1}, 32'd0);
    chk("busy_in_flight", {31'd0, busy1}, 32'd1);
    settle();
    chk("drop_rate_kept", rate1, 32'd7);
    chk("drop_err_kept", {31'd0, re1}, 32'd1);
    chk("drop_x_held", x1, 32'd131072);

    // Reset mid-S_WAIT; the late done from the responder must be ignored.
    en1 = 1'b1;
    pulse(2, 1'b1);
    repeat (4) pulse(3, 1'b1);
    xq1.push_back(32'd196608);
    repeat (5) tick();
    chk("busy_before_rst", {31'd0, busy1}, 32'd1);
    rst = 1'b1;
    tick();
    chk_reset("midrst");
    rst = 1'b0;
    en1 = 1'b0;
    repeat (12) tick();
    chk("late_done_busy", {31'd0, busy1}, 32'd0);
    chk("late_done_rate", rate1, 32'd0);

    // Single-interval windows every 2 cycles: first accepted, next five dropped.
    en0 = 1'b1;
    pulse(2, 1'b0);
    pulse(2, 1'b0);
    xq0.push_back(32'd131072);
    e.rate = 32'd32768;
    e.err  = 1'b0;
    e.cyc  = last_hb + 13;
    rq0.push_back(e);
    repeat (5) pulse(2, 1'b0);
    chk("overrun0_set", {31'd0, ovr0}, 32'd1);
    repeat (4) tick();
    chk("overrun0_sticky", {31'd0, ovr0}, 32'd1);
    chk("rate0_held", rate0, 32'd32768);
    settle();

    chk("rq1_drained", 32'(rq1.size()), 32'd0);
    chk("xq1_drained", 32'(xq1.size()), 32'd0);
    chk("rq0_drained", 32'(rq0.size()), 32'd0);
    chk("xq0_drained", 32'(xq0.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hb_period_meter.md
# hb_period_meter

Measures the interval between heartbeat pulses in clock cycles and averages 2^AVG_LOG2 consecutive intervals. It converts the average to signed QF fixed point and sequences the watchdog reciprocal unit through its start/done handshake. It publishes the resulting heartbeat rate (cycles⁻¹, QF) with a one-cycle valid strobe. It sits directly upstream of the reciprocal unit and drives its `start_calc`/`x_in` inputs.

## Interface
- `W`, 32, datapath width (bits); matches reciprocal unit
- `F`, 16, fractional bits of QF format; matches reciprocal unit
- `AVG_LOG2`, 2, log2 of intervals per averaging window (0..4)
- `clk`  in  1  single clock; all logic rising-edge
- `rst`  in  1  reset, synchronous, active-high
- `enable`  in  1  measurement enable; low clears measurement state
- `hb_in`  in  1  heartbeat, single-cycle pulse, already synchronous to `clk`
- `recip_start`  out  1  to reciprocal `start_calc`; one-cycle pulse
- `recip_x`  out  W  to reciprocal `x_in`; signed QF average period
- `recip_done`  in  1  from reciprocal `done`
- `recip_inv`  in  W  from reciprocal `x_inv`
- `recip_invalid`  in  1  from reciprocal `invalid`; sampled only with `recip_done`
- `rate_out`  out  W  last published rate, QF
- `rate_valid`  out  1  one-cycle strobe, `rate_out`/`rate_err` updated
- `rate_err`  out  1  published rate unreliable (saturated period or invalid reciprocal)
- `busy`  out  1  FSM not in S_IDLE
- `overrun`  out  1  sticky: a completed window was dropped; cleared by `rst` or `enable` low

## Operation
- PMAX = 2^(W-1-F) − 1 (32767 at defaults): the largest integer period representable as positive signed QF.
- Period counter `cnt`:
  - 0 on reset or while `enable` is low.
  - Increments by 1 per cycle and saturates at PMAX.
  - On `hb_in`, it reloads to 1.
- Interval sample:
  - The first `hb_in` after `enable` rises only arms the meter; no sample is taken.
  - Each later `hb_in` yields sample = `cnt` (cycles since the previous pulse).
  - `sat` flag = (`cnt` == PMAX).
- Accumulator: the sum is W+AVG_LOG2 bits wide, with a sample counter 0..2^AVG_LOG2−1.
  - When the window fills, avg = sum >> AVG_LOG2 (truncate) and x = avg << F.
  - A window's `sat` = OR of all per-sample `sat` flags in that window.
  - The accumulator and sample counter clear, and the next window starts with the next sample.
- FSM states:
  - S_IDLE:
    - On window complete, latch x into `recip_x` and latch the window `sat` into `err_sat`.
    - Then go to S_REQ.
  - S_REQ: assert `recip_start` for exactly this cycle, then go to S_WAIT.
  - S_WAIT:
    - Hold `recip_x` stable until `recip_done`.
    - On `recip_done`, capture `recip_inv` and `recip_invalid`, then go to S_OUT.
  - S_OUT: update the outputs as follows, then return to S_IDLE.
    - `rate_out` = captured inv.
    - `rate_err` = invalid | `err_sat`.
    - `rate_valid` = 1, unless the `drop` flag is set (see the `enable`-low rule below).
- Window completes while FSM is not in S_IDLE: discard that window and set `overrun`. Measurement continues uninterrupted.
- `enable` low:
  - Clears `cnt`, the accumulator, the arming state and `overrun`.
  - If the FSM is in S_REQ/S_WAIT, the in-flight request still completes so the reciprocal handshake stays coherent.
  - In that case, set `drop`; S_OUT then suppresses `rate_valid` and leaves `rate_out`/`rate_err` unchanged.
- `hb_in` in the same cycle `enable` rises counts as the arming pulse.

## Timing
- Reset values:
  - `recip_start`=0, `recip_x`=0, `rate_out`=0, `rate_valid`=0, `rate_err`=0, `busy`=0, `overrun`=0.
  - FSM in S_IDLE.
- Window completion is registered on the cycle of the last `hb_in`. S_IDLE latches `recip_x` on the next cycle, and `recip_start` is high the cycle after that.
- `rate_valid` rises exactly 2 cycles after the cycle `recip_done` is sampled high (S_WAIT→S_OUT, S_OUT registers the outputs).
- End-to-end latency from last `hb_in` to `rate_valid` = 4 + reciprocal latency. The reciprocal latency is 9 cycles from start to done.
- `recip_done` outside S_WAIT is ignored.
- `rst` mid-operation returns everything to reset values on the next edge. The reciprocal unit is reset by the same system reset.

## Test plan
The bench uses a behavioural reciprocal responder:
- It samples `recip_x` at `recip_start`.
- It asserts `recip_done` 9 cycles later.
- It returns `recip_inv` = floor(2^(2F)/x) and `recip_invalid` = (x ≤ 0).

Scenarios:
- Defaults, `hb_in` every 4 cycles, 5 pulses → `recip_x`=262144, one `rate_valid` with `rate_out`=16384 and `rate_err`=0, 13 cycles after the 5th pulse.
- Intervals 3,5,4,6 cycles → avg = 18>>2 = 4 → `recip_x`=262144 and `rate_out`=16384 (checks truncation and summation).
- One interval > 32767 cycles inside a window → `cnt` saturates, `recip_x` = (sum>>2)<<16, `rate_err`=1 on `rate_valid`.
- `AVG_LOG2`=0, `hb_in` every 2 cycles → second window completes during S_WAIT → `overrun`=1 stays set; one `rate_valid` per accepted window, `rate_out`=32768.
- `enable` dropped during S_WAIT → `recip_start` not re-issued, request completes, no `rate_valid`, `rate_out` keeps its previous value, `overrun` cleared.
- `rst` pulsed mid-S_WAIT → all outputs at reset values next cycle; a subsequent late `recip_done` is ignored.
